alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL support any WIDTH >= 4 that is a power of two.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 alu_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SAR (arithmetic right), 111 MUL.
REQ-005 alu_a, alu_b  input  WIDTH  operands, sampled only on accept.
REQ-006 in_valid  input  1  request present; in_ready  output  1  block can accept.
REQ-007 alu_out  output  WIDTH  registered result.
REQ-008 z, v, n, c  output  1 each  registered flags: zero, signed overflow, sign, carry/borrow/shift-out.
REQ-009 out_valid  output  1  result valid; out_ready  input  1  consumer takes result.

Function
REQ-010 States: IDLE, MUL, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-011 Accept = in_valid & in_ready at a rising edge; operands and opcode SHALL be captured at accept and never resampled.
REQ-012 Non-MUL ops: IDLE -> HOLD at accept; result and flags registered that edge; out_valid=1 on the following cycle (latency 1).
REQ-013 MUL: IDLE -> MUL at accept; shift-add, one operand bit per cycle, exactly WIDTH cycles in MUL, then -> HOLD; out_valid asserts WIDTH+1 cycles after accept.
REQ-014 HOLD: out_valid=1; alu_out and flags SHALL stay stable; on out_ready -> IDLE, out_valid=0 next cycle; no same-cycle new accept.
REQ-015 in_valid while not IDLE SHALL be ignored with no state change.
REQ-016 For all ops n = alu_out[WIDTH-1]; z = (alu_out == 0).
REQ-017 ADD: alu_out = (a+b) mod 2^WIDTH; c = carry-out; v = operands same sign and result sign differs.
REQ-018 SUB: alu_out = (a-b) mod 2^WIDTH; c = 1 iff a < b unsigned (borrow); v = operands differ in sign and result sign differs from a.
REQ-019 AND/OR/XOR: bitwise; c = v = 0.
REQ-020 SHL/SAR: shift amount = b[log2(WIDTH)-1:0]; SAR replicates a's sign bit; c = last bit shifted out, c = 0 for amount 0; v = 0.
REQ-021 MUL: unsigned product; alu_out = low WIDTH bits; v = 1 iff high WIDTH bits nonzero; c = 0.
REQ-022 Flags and alu_out SHALL change only on the transition into HOLD.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, alu_out=0, z=v=n=c=0, out_valid=0, in_ready=0 during the reset cycle, in_ready=1 on the first cycle after rst deasserts.
REQ-024 Reset SHALL take priority over accept, MUL iteration and HOLD; a MUL in progress is aborted with no result emitted.

Verification (WIDTH=16)
REQ-025 ADD a=0x7FFF b=0x0001 accepted at edge k -> out_valid at k+1, alu_out=0x8000, n=1 v=1 z=0 c=0.
REQ-026 SUB a=0x0000 b=0x0001 -> 0xFFFF, n=1 c=1 v=0 z=0; ADD 0xFFFF+0x0001 -> 0x0000, z=1 c=1 v=0 n=0.
REQ-027 MUL 0x00FF*0x0101 -> out_valid exactly 17 cycles after accept, 0xFFFF, v=0 n=1; MUL 0x0100*0x0100 -> 0x0000, z=1 v=1.
REQ-028 SHL 0x8001 by 1 -> 0x0002 c=1; SAR 0x8000 by 15 -> 0xFFFF c=0 n=1; SAR by 0 -> unchanged, c=0.
REQ-029 Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 and changing operands -> outputs stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
REQ-030 rst pulse 5 cycles into a MUL -> out_valid never asserts for it, outputs 0, in_ready=1 after reset; then ADD 1+1 -> 0x0002, all flags 0.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with shift-add multiplier and valid/ready handshakes
//
// Purpose: single-issue ALU. ADD/SUB/AND/OR/XOR/SHL/SAR finish at the accept
// edge. MUL runs a WIDTH-cycle shift-add loop. The result and flags are then
// held until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   alu_op     opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SAR, 7 MUL
//   alu_a/b    operands, sampled only on accept
//   in_valid   request present
//   in_ready   block can accept (IDLE only)
//   alu_out    registered result
//   z/v/n/c    registered zero / signed overflow / sign / carry-borrow-shiftout
//   out_valid  result held and valid
//   out_ready  consumer takes the result
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SAR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             mul_done;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] prod_hi_nxt;
  logic [WIDTH-1:0] prod_lo_nxt;

  logic [SW-1:0]    amt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH:0]   sar_full;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  // Reset masks in_ready so nothing is accepted during the reset cycle.
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);
  assign mul_done  = (state == ST_MUL) && (cnt == SW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = (alu_op == OP_MUL) ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_done)  state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle ops, evaluated straight from the inputs at the accept edge.
  // Shifts carry one extra bit so the last bit shifted out lands in it; with
  // a zero amount that bit is the injected 0, which gives c = 0.
  always_comb begin
    amt      = alu_b[SW-1:0];
    add_full = {1'b0, alu_a} + {1'b0, alu_b};
    sub_full = {1'b0, alu_a} - {1'b0, alu_b};
    shl_full = {1'b0, alu_a} << amt;
    sar_full = $signed({alu_a, 1'b0}) >>> amt;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res   = add_full[WIDTH-1:0];
        res_c = add_full[WIDTH];
        res_v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_full[WIDTH-1:0];
        res_c = sub_full[WIDTH];
        res_v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_AND: res = alu_a & alu_b;
      OP_OR:  res = alu_a | alu_b;
      OP_XOR: res = alu_a ^ alu_b;
      OP_SHL: begin
        res   = shl_full[WIDTH-1:0];
        res_c = shl_full[WIDTH];
      end
      OP_SAR: begin
        res   = sar_full[WIDTH:1];
        res_c = sar_full[0];
      end
      default: ;
    endcase
  end

  // One shift-add step: {prod_hi, prod_lo} holds the partial product in its
  // upper bits and the unconsumed multiplier bits in its lower bits.
  always_comb begin
    mul_sum     = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    prod_hi_nxt = mul_sum[WIDTH:1];
    prod_lo_nxt = {mul_sum[0], prod_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= '0;
      z       <= 1'b0;
      v       <= 1'b0;
      n       <= 1'b0;
      c       <= 1'b0;
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      cnt     <= '0;
    end else if (accept) begin
      if (alu_op == OP_MUL) begin
        mcand   <= alu_a;
        prod_lo <= alu_b;
        prod_hi <= '0;
        cnt     <= '0;
      end else begin
        alu_out <= res;
        z       <= (res == '0);
        v       <= res_v;
        n       <= res[WIDTH-1];
        c       <= res_c;
      end
    end else if (state == ST_MUL) begin
      prod_hi <= prod_hi_nxt;
      prod_lo <= prod_lo_nxt;
      cnt     <= cnt + 1'b1;
      if (mul_done) begin
        alu_out <= prod_lo_nxt;
        z       <= (prod_lo_nxt == '0);
        v       <= |prod_hi_nxt;
        n       <= prod_lo_nxt[WIDTH-1];
        c       <= 1'b0;
      end
    end
  end

endmodule
